// File: rtl/auth_slot_scheduler.sv
// auth_slot_scheduler
// Round-robin arbiter that shares one authentication responder among four
// Type-C authentication slots. It latches a slot's message, drives the
// responder handshake, supervises the response against the responder's
// timeout, and reports done / timeout per slot. A per-slot holdoff window
// after each completion turns early re-requests into Busy replies.
module auth_slot_scheduler #(
   parameter int MSG_LEN  = 64,
   parameter int TICK_DIV = 1,
   parameter int HOLDOFF  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           req_valid,
   input  logic [4*MSG_LEN-1:0] req_msg,
   output logic [3:0]           req_ack,
   output logic [3:0]           done,
   output logic [3:0]           timeout_err,
   output logic                 resp_req_in,
   output logic [MSG_LEN-1:0]   auth_msg_resp_in,
   output logic [1:0]           slot,
   output logic                 Error_Busy,
   output logic                 Ack_in,
   output logic                 resp_reset,
   input  logic                 resp_req_out,
   input  logic [31:0]          current_timeout,
   output logic                 busy
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ISSUE     = 3'd1;
   localparam logic [2:0] S_WAIT_RESP = 3'd2;
   localparam logic [2:0] S_ACK       = 3'd3;
   localparam logic [2:0] S_ABORT     = 3'd4;
   localparam logic [2:0] S_RELEASE   = 3'd5;

   localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

   logic [2:0]         state_q, state_d;
   logic [1:0]         last_grant_q, last_grant_d;
   logic [1:0]         slot_q, slot_d;
   logic [MSG_LEN-1:0] msg_q, msg_d;
   logic [3:0]         req_ack_q, req_ack_d;
   logic [3:0]         done_q, done_d;
   logic [3:0]         terr_q, terr_d;
   logic               resp_req_in_q, resp_req_in_d;
   logic               err_busy_q, err_busy_d;
   logic               ack_in_q, ack_in_d;
   logic               resp_reset_q, resp_reset_d;
   logic               busy_q, busy_d;
   logic               busy_reply_q, busy_reply_d;
   logic [15:0]        presc_q, presc_d;
   logic [31:0]        tick_q, tick_d;
   logic [HW-1:0]      holdoff_q [4];
   logic [HW-1:0]      holdoff_d [4];

   logic [1:0]         winner, cand;
   logic               found;
   logic [MSG_LEN-1:0] msg_sel;

   // Round-robin search starting one past the last granted slot.
   always_comb begin
      // NOTE: every combinationally driven variable gets a default before any
      // conditional assignment, otherwise synthesis infers a latch.
      cand   = 2'd0;
      winner = last_grant_q;
      found  = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cand = last_grant_q + 2'(i);
         if (!found && req_valid[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // Message mux for the winning slot, using constant part-select bases.
   always_comb begin
      msg_sel = '0;
      for (int i = 0; i < 4; i++) begin
         if (winner == 2'(i)) msg_sel = req_msg[i*MSG_LEN +: MSG_LEN];
      end
   end

   // Holdoff counters: free-running decrement, reloaded on a normal completion.
   always_comb begin
      for (int s = 0; s < 4; s++) begin
         holdoff_d[s] = (holdoff_q[s] != '0) ? holdoff_q[s] - HW'(1) : '0;
         if (state_q == S_ACK && !busy_reply_q && slot_q == 2'(s))
            holdoff_d[s] = HW'(HOLDOFF);
      end
   end

   // FSM next state and next values of every registered output.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      slot_d        = slot_q;
      msg_d         = msg_q;
      presc_d       = presc_q;
      tick_d        = tick_q;
      busy_reply_d  = busy_reply_q;
      req_ack_d     = 4'b0000;
      done_d        = 4'b0000;
      terr_d        = 4'b0000;
      resp_req_in_d = 1'b0;
      err_busy_d    = 1'b0;
      ack_in_d      = 1'b0;
      resp_reset_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d       = S_ISSUE;
               msg_d         = msg_sel;
               slot_d        = winner;
               last_grant_d  = winner;
               req_ack_d     = 4'b0001 << winner;
               resp_req_in_d = 1'b1;
               // Busy is judged on the holdoff value seen during ISSUE.
               err_busy_d    = (holdoff_d[winner] != '0);
               busy_reply_d  = (holdoff_d[winner] != '0);
            end
         end
         S_ISSUE: begin
            presc_d = '0;
            tick_d  = '0;
            state_d = S_WAIT_RESP;
         end
         S_WAIT_RESP: begin
            if (presc_q == 16'(TICK_DIV - 1)) begin
               presc_d = '0;
               tick_d  = (tick_q == '1) ? tick_q : tick_q + 32'd1;
            end else begin
               presc_d = presc_q + 16'd1;
            end
            // A response arriving in the same cycle as the timeout wins.
            if (resp_req_out) begin
               state_d  = S_ACK;
               ack_in_d = 1'b1;
               done_d   = 4'b0001 << slot_q;
            end else if (tick_q >= current_timeout) begin
               state_d      = S_ABORT;
               resp_reset_d = 1'b1;
               terr_d       = 4'b0001 << slot_q;
            end
         end
         S_ACK:     state_d = S_RELEASE;
         S_ABORT:   state_d = S_RELEASE;
         S_RELEASE: if (!resp_req_out) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q       <= S_IDLE;
         last_grant_q  <= 2'd3;
         slot_q        <= 2'd0;
         msg_q         <= '0;
         req_ack_q     <= 4'b0000;
         done_q        <= 4'b0000;
         terr_q        <= 4'b0000;
         resp_req_in_q <= 1'b0;
         err_busy_q    <= 1'b0;
         ack_in_q      <= 1'b0;
         resp_reset_q  <= 1'b0;
         busy_q        <= 1'b0;
         busy_reply_q  <= 1'b0;
         presc_q       <= '0;
         tick_q        <= '0;
         for (int s = 0; s < 4; s++) holdoff_q[s] <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         slot_q        <= slot_d;
         msg_q         <= msg_d;
         req_ack_q     <= req_ack_d;
         done_q        <= done_d;
         terr_q        <= terr_d;
         resp_req_in_q <= resp_req_in_d;
         err_busy_q    <= err_busy_d;
         ack_in_q      <= ack_in_d;
         resp_reset_q  <= resp_reset_d;
         busy_q        <= busy_d;
         busy_reply_q  <= busy_reply_d;
         presc_q       <= presc_d;
         tick_q        <= tick_d;
         for (int s = 0; s < 4; s++) holdoff_q[s] <= holdoff_d[s];
      end
   end

   assign req_ack          = req_ack_q;
   assign done             = done_q;
   assign timeout_err      = terr_q;
   assign resp_req_in      = resp_req_in_q;
   assign auth_msg_resp_in = msg_q;
   assign slot             = slot_q;
   assign Error_Busy       = err_busy_q;
   assign Ack_in           = ack_in_q;
   assign resp_reset       = resp_reset_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_auth_slot_scheduler.sv
// tb_auth_slot_scheduler
// Directed bench for auth_slot_scheduler: the responder side is driven by
// hand and every expected value is written out for each step.
module tb_auth_slot_scheduler;

   logic         clk;
   logic         reset;
   logic [3:0]   req_valid;
   logic [255:0] req_msg;
   logic [3:0]   req_ack;
   logic [3:0]   done;
   logic [3:0]   timeout_err;
   logic         resp_req_in;
   logic [63:0]  auth_msg_resp_in;
   logic [1:0]   slot;
   logic         Error_Busy;
   logic         Ack_in;
   logic         resp_reset;
   logic         resp_req_out;
   logic [31:0]  current_timeout;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   auth_slot_scheduler #(.MSG_LEN(64), .TICK_DIV(1), .HOLDOFF(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_msg          (req_msg),
      .req_ack          (req_ack),
      .done             (done),
      .timeout_err      (timeout_err),
      .resp_req_in      (resp_req_in),
      .auth_msg_resp_in (auth_msg_resp_in),
      .slot             (slot),
      .Error_Busy       (Error_Busy),
      .Ack_in           (Ack_in),
      .resp_reset       (resp_reset),
      .resp_req_out     (resp_req_out),
      .current_timeout  (current_timeout),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full transaction for exp_slot: wait (bounded) for the grant, check
   // ISSUE outputs, answer after three WAIT cycles, check ACK, hold the
   // response high for two RELEASE cycles, then drop it.
   task automatic do_grant(input logic [1:0] exp_slot, input logic [3:0] hold_mask,
                           input logic exp_busy_err, input string tag);
      int          n;
      logic [3:0]  oh;
      logic [63:0] exp_msg;
      oh      = 4'b0001 << exp_slot;
      exp_msg = req_msg[exp_slot*64 +: 64];
      n = 0;
      while (req_ack == 4'b0000 && n < 12) begin
         step();
         n++;
      end
      check({tag, "_ack"},     64'(req_ack), 64'(oh));
      check({tag, "_slot"},    64'(slot), 64'(exp_slot));
      check({tag, "_msg"},     auth_msg_resp_in, exp_msg);
      check({tag, "_issue"},   64'({resp_req_in, Error_Busy}), 64'({1'b1, exp_busy_err}));
      req_valid = hold_mask;
      step();
      check({tag, "_issue_1cyc"}, 64'({resp_req_in, Error_Busy}), 64'(2'b00));
      step();
      step();
      resp_req_out = 1'b1;
      step();
      check({tag, "_done"},    64'({done, Ack_in, timeout_err}), 64'({oh, 1'b1, 4'b0000}));
      step();
      step();
      check({tag, "_hold"},    64'({busy, req_ack, Ack_in}), 64'({1'b1, 4'b0000, 1'b0}));
      resp_req_out = 1'b0;
   endtask

   initial begin
      int bad;
      reset           = 1'b1;
      req_valid       = 4'b0000;
      resp_req_out    = 1'b0;
      current_timeout = 32'd1000;
      req_msg[63:0]    = 64'hA0A0_0000_0000_00A0;
      req_msg[127:64]  = 64'hB1B1_1111_0000_00B1;
      req_msg[191:128] = 64'h0183_0000_0000_0000;
      req_msg[255:192] = 64'hC3C3_3333_0000_00C3;

      // Reset values.
      repeat (3) step();
      check("rst_pulses", 64'({req_ack, done, timeout_err}), 64'(12'h000));
      check("rst_ctrl",   64'({resp_req_in, Error_Busy, Ack_in, resp_reset, busy, slot}), 64'(7'b0));
      check("rst_msg",    auth_msg_resp_in, 64'h0);
      reset = 1'b0;
      step();
      check("idle_busy", 64'(busy), 64'(1'b0));

      // All four slots request continuously: grants go 0,1,2,3,0.
      req_valid = 4'b1111;
      do_grant(2'd0, 4'b1111, 1'b0, "rr0");
      do_grant(2'd1, 4'b1111, 1'b0, "rr1");
      do_grant(2'd2, 4'b1111, 1'b0, "rr2");
      do_grant(2'd3, 4'b1111, 1'b0, "rr3");
      do_grant(2'd0, 4'b0000, 1'b0, "rr4");
      repeat (20) step();

      // Slot 2 alone, responder answers 10 cycles after ISSUE.
      req_valid = 4'b0100;
      step();
      check("s2_ack",   64'({req_ack, slot, resp_req_in, busy}), 64'({4'b0100, 2'd2, 1'b1, 1'b1}));
      check("s2_msg",   auth_msg_resp_in, 64'h0183_0000_0000_0000);
      req_valid = 4'b0000;
      step();
      check("s2_req_in_1cyc", 64'({resp_req_in, req_ack}), 64'(5'b0));
      repeat (8) step();
      check("s2_no_early_done", 64'({done, Ack_in}), 64'(5'b0));
      resp_req_out = 1'b1;
      step();
      check("s2_done",  64'({done, Ack_in}), 64'({4'b0100, 1'b1}));
      step();
      check("s2_ack_1cyc", 64'({done, Ack_in, busy}), 64'({4'b0000, 1'b0, 1'b1}));
      resp_req_out = 1'b0;
      step();
      check("s2_idle",  64'(busy), 64'(1'b0));
      repeat (3) step();

      // Timeout: current_timeout=20, no answer; slot 0 waits behind slot 3.
      current_timeout = 32'd20;
      req_valid = 4'b1001;
      step();
      check("to_ack", 64'({req_ack, slot}), 64'({4'b1000, 2'd3}));
      req_valid = 4'b0001;
      bad = 0;
      for (int i = 0; i < 21; i++) begin
         step();
         if (timeout_err != 4'b0000 || resp_reset !== 1'b0) bad++;
      end
      check("to_not_early", 64'(bad), 64'(0));
      step();
      check("to_fire",  64'({timeout_err, resp_reset, done, Ack_in}), 64'({4'b1000, 1'b1, 4'b0000, 1'b0}));
      step();
      check("to_1cyc",  64'({timeout_err, resp_reset, busy}), 64'({4'b0000, 1'b0, 1'b1}));
      current_timeout = 32'd1000;
      do_grant(2'd0, 4'b0000, 1'b0, "to_next");
      repeat (20) step();

      // Holdoff: slot 1 re-requests 3 cycles after done -> Busy reply, no reload.
      req_valid = 4'b0010;
      do_grant(2'd1, 4'b0000, 1'b0, "ho_first");
      step();
      req_valid = 4'b0010;
      do_grant(2'd1, 4'b0000, 1'b1, "ho_busy");
      repeat (8) step();
      req_valid = 4'b0010;
      do_grant(2'd1, 4'b0000, 1'b0, "ho_after");
      repeat (3) step();

      // Response and timeout reached in the same cycle: response wins.
      current_timeout = 32'd3;
      req_valid = 4'b0100;
      step();
      check("tie_ack", 64'(req_ack), 64'(4'b0100));
      req_valid = 4'b0000;
      repeat (4) step();
      resp_req_out = 1'b1;
      step();
      check("tie_done", 64'({done, timeout_err, resp_reset}), 64'({4'b0100, 4'b0000, 1'b0}));
      step();
      check("tie_no_to", 64'({timeout_err, resp_reset}), 64'(5'b0));
      resp_req_out = 1'b0;
      step();
      check("tie_idle", 64'(busy), 64'(1'b0));

      // current_timeout=0 aborts on the first WAIT_RESP cycle.
      current_timeout = 32'd0;
      req_valid = 4'b1000;
      step();
      check("zero_ack", 64'(req_ack), 64'(4'b1000));
      req_valid = 4'b0000;
      step();
      step();
      check("zero_fire", 64'({timeout_err, resp_reset}), 64'({4'b1000, 1'b1}));
      repeat (2) step();
      check("zero_idle", 64'(busy), 64'(1'b0));
      current_timeout = 32'd1000;

      // Reset during WAIT_RESP, then slot 0 wins with all slots requesting.
      req_valid = 4'b0010;
      step();
      check("rw_ack", 64'(req_ack), 64'(4'b0010));
      req_valid = 4'b0000;
      step();
      step();
      reset = 1'b1;
      step();
      check("rw_pulses", 64'({req_ack, done, timeout_err}), 64'(12'h000));
      check("rw_ctrl",   64'({resp_req_in, Error_Busy, Ack_in, resp_reset, busy, slot}), 64'(7'b0));
      check("rw_msg",    auth_msg_resp_in, 64'h0);
      reset = 1'b0;
      req_valid = 4'b1111;
      do_grant(2'd0, 4'b0000, 1'b0, "rw_next");
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
